// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline stall/flush controller.
// Contents: controller state enum, register-zero index, default multiply latency,
// and a packed bundle of the eight stage-control bits with its canonical patterns.
package pipe_ctrl_pkg;
    typedef enum logic {RUN, MUL} state_e;
    localparam int REG_ZERO = 0;
    localparam int MUL_LAT_DEF = 4;
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic exmem_flush;
        logic memwb_en;
    } stage_ctrl_t;
    // Bit order matches the struct: pc_en first, memwb_en last.
    localparam stage_ctrl_t CTRL_RUN = 8'b1101_0101;
    localparam stage_ctrl_t CTRL_RST = 8'b0010_1010;
    localparam stage_ctrl_t CTRL_FRZ = 8'b0000_0000;
    localparam stage_ctrl_t CTRL_BR  = 8'b1111_1101;
    localparam stage_ctrl_t CTRL_MUL = 8'b0000_0111;
    localparam stage_ctrl_t CTRL_LU  = 8'b0001_1101;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use compare between the ID sources and the EX load.
// Ports: id_rs/id_rt + use flags from ID, ex_rd/ex_mem_read from EX, load_use result.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic            id_uses_rs,
    input  logic            id_uses_rt,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            ex_mem_read,
    output logic            load_use
);
    assign load_use = ex_mem_read & (ex_rd != RA_W'(REG_ZERO)) &
                      ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for the 5-stage pipeline registers and PC.
// Inputs: ID source fields, EX load/multiply/branch status, data-memory handshake.
// Outputs: per-stage enable/flush lines (combinational) and a 32-bit stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int RA_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic            id_uses_rs,
    input  logic            id_uses_rt,
    input  logic [RA_W-1:0] ex_rd,
    input  logic            ex_mem_read,
    input  logic            ex_is_mul,
    input  logic            ex_branch_taken,
    input  logic            dmem_req,
    input  logic            dmem_ready,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            ifid_flush,
    output logic            idex_en,
    output logic            idex_flush,
    output logic            exmem_en,
    output logic            exmem_flush,
    output logic            memwb_en,
    output logic [31:0]     stall_cycles
);
    // The trigger cycle is the first stalled EX cycle, so MUL holds MUL_LAT-2 more
    // cycles; the counter stores how many MUL cycles remain after the current one.
    localparam logic [3:0] MUL_INIT = 4'(MUL_LAT > 2 ? MUL_LAT - 3 : 0);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [31:0] stall_q;
    logic        frz, load_use, mul_trig;
    stage_ctrl_t ctrl;

    hazard_detect #(.RA_W(RA_W)) u_hd (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .ex_rd      (ex_rd),
        .ex_mem_read(ex_mem_read),
        .load_use   (load_use)
    );

    always_comb begin
        frz      = dmem_req & ~dmem_ready;
        mul_trig = ex_is_mul & ~done_q & (MUL_LAT > 1);
        ctrl     = CTRL_RUN;
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = done_q;
        if (rst) begin
            ctrl = CTRL_RST;
        end else if (frz) begin
            ctrl = CTRL_FRZ;
        end else if (state_q == MUL) begin
            ctrl = CTRL_MUL;
            if (cnt_q == 4'd0) begin
                state_d = RUN;
                done_d  = 1'b1;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else if (ex_branch_taken) begin
            ctrl   = CTRL_BR;
            done_d = 1'b0;
        end else if (mul_trig) begin
            ctrl = CTRL_MUL;
            // A two-cycle multiply is fully covered by the trigger cycle itself.
            if (MUL_LAT > 2) begin
                state_d = MUL;
                cnt_d   = MUL_INIT;
            end else begin
                done_d = 1'b1;
            end
        end else if (load_use) begin
            ctrl   = CTRL_LU;
            done_d = 1'b0;
        end else begin
            done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
            done_q  <= 1'b0;
            stall_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (!ctrl.pc_en) stall_q <= stall_q + 32'd1;
        end
    end

    assign pc_en        = ctrl.pc_en;
    assign ifid_en      = ctrl.ifid_en;
    assign ifid_flush   = ctrl.ifid_flush;
    assign idex_en      = ctrl.idex_en;
    assign idex_flush   = ctrl.idex_flush;
    assign exmem_en     = ctrl.exmem_en;
    assign exmem_flush  = ctrl.exmem_flush;
    assign memwb_en     = ctrl.memwb_en;
    assign stall_cycles = stall_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rs, id_uses_rt, ex_mem_read, ex_is_mul, ex_branch_taken;
    logic        dmem_req, dmem_ready;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en;
    logic [31:0] stall_cycles;
    logic [7:0]  ctrl;
    int          errors = 0;
    int          checks = 0;

    localparam logic [7:0] E_RUN = 8'hD5;
    localparam logic [7:0] E_RST = 8'h2A;
    localparam logic [7:0] E_FRZ = 8'h00;
    localparam logic [7:0] E_BR  = 8'hFD;
    localparam logic [7:0] E_MUL = 8'h07;
    localparam logic [7:0] E_LU  = 8'h1D;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rs     (id_uses_rs),
        .id_uses_rt     (id_uses_rt),
        .ex_rd          (ex_rd),
        .ex_mem_read    (ex_mem_read),
        .ex_is_mul      (ex_is_mul),
        .ex_branch_taken(ex_branch_taken),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .ifid_flush     (ifid_flush),
        .idex_en        (idex_en),
        .idex_flush     (idex_flush),
        .exmem_en       (exmem_en),
        .exmem_flush    (exmem_flush),
        .memwb_en       (memwb_en),
        .stall_cycles   (stall_cycles)
    );

    assign ctrl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic run(input string tag, input logic [7:0] exp);
        @(negedge clk);
        check(tag, 32'(ctrl), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        ex_is_mul = 1'b0; ex_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic set_lu_rt(input logic [4:0] rd);
        ex_mem_read = 1'b1; ex_rd = rd; id_uses_rt = 1'b1; id_rt = rd;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        run("rst_c0", E_RST);
        run("rst_c1", E_RST);
        rst = 1'b0;
        check("stall_after_rst", stall_cycles, 32'd0);
        run("idle", E_RUN);

        set_lu_rt(5'd5);
        run("lu_rt", E_LU);
        idle_inputs();
        check("stall_lu", stall_cycles, 32'd1);
        run("lu_cleared", E_RUN);

        set_lu_rt(5'd0);
        run("lu_r0", E_RUN);
        idle_inputs();
        check("stall_r0", stall_cycles, 32'd1);

        ex_mem_read = 1'b1; ex_rd = 5'd7; id_uses_rs = 1'b1; id_rs = 5'd7;
        run("lu_rs", E_LU);
        id_uses_rs = 1'b0;
        run("rs_unused", E_RUN);
        idle_inputs();
        check("stall_rs", stall_cycles, 32'd2);

        set_lu_rt(5'd5);
        ex_branch_taken = 1'b1;
        run("br_over_lu", E_BR);
        idle_inputs();
        check("stall_br", stall_cycles, 32'd2);

        ex_is_mul = 1'b1;
        run("mul_c0", E_MUL);
        run("mul_c1", E_MUL);
        run("mul_c2", E_MUL);
        run("mul_adv", E_RUN);
        ex_is_mul = 1'b0;
        check("stall_mul", stall_cycles, 32'd5);

        dmem_req = 1'b1;
        run("frz_run", E_FRZ);
        dmem_ready = 1'b1;
        run("dmem_ready", E_RUN);
        idle_inputs();
        check("stall_frz_run", stall_cycles, 32'd6);

        ex_is_mul = 1'b1;
        run("mf_c0", E_MUL);
        run("mf_c1", E_MUL);
        dmem_req = 1'b1;
        run("mf_frz0", E_FRZ);
        run("mf_frz1", E_FRZ);
        dmem_req = 1'b0;
        run("mf_c2", E_MUL);
        run("mf_adv", E_RUN);
        ex_is_mul = 1'b0;
        check("stall_mul_frz", stall_cycles, 32'd11);

        ex_is_mul = 1'b1;
        run("rm_c0", E_MUL);
        run("rm_c1", E_MUL);
        rst = 1'b1;
        run("rm_rst", E_RST);
        rst = 1'b0;
        ex_is_mul = 1'b0;
        check("stall_rm", stall_cycles, 32'd0);
        run("rm_run", E_RUN);
        ex_is_mul = 1'b1;
        run("rm_new0", E_MUL);
        run("rm_new1", E_MUL);
        run("rm_new2", E_MUL);
        run("rm_newadv", E_RUN);
        ex_is_mul = 1'b0;
        check("stall_rm_new", stall_cycles, 32'd3);

        force dut.stall_q = 32'hFFFF_FFFF;
        #1;
        check("forced", stall_cycles, 32'hFFFF_FFFF);
        release dut.stall_q;
        set_lu_rt(5'd9);
        run("wrap_lu", E_LU);
        idle_inputs();
        check("stall_wrap", stall_cycles, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
